an_sec_search: RTL and testbench
================================

AN_SEC_SEARCH -- requirements
Module: an_sec_search

Interface
REQ-001 The block SHALL have parameter A, default 6311, meaning the AN-code modulus, which must be odd and greater than 2.
REQ-002 The block SHALL have parameter RW, default 13, meaning the remainder width, equal to ceil(log2(A)).
REQ-003 The block SHALL have parameter CW, default 33, meaning the codeword width.
REQ-004 The block SHALL have parameter NPOS, default 33 (≤ CW), meaning the number of searchable error bit positions.
REQ-005 The block SHALL have parameter LW, default 7, meaning the signed location width, equal to clog2(NPOS+1)+1.
REQ-006 The block SHALL have port clk  in  1  sole clock, with all state updating on its rising edge.
REQ-007 The block SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-008 The block SHALL have port in_valid  in  1  input request valid.
REQ-009 The block SHALL have port in_ready  out  1  block can accept a request.
REQ-010 The block SHALL have port in_code  in  CW  received codeword.
REQ-011 The block SHALL have port in_rem  in  RW  remainder in_code mod A, as supplied by the upstream syndrome stage.
REQ-012 The block SHALL have port out_valid  out  1  result valid.
REQ-013 The block SHALL have port out_ready  in  1  downstream accepts the result.
REQ-014 The block SHALL have port out_code  out  CW  corrected codeword.
REQ-015 The block SHALL have port out_loc  out  LW signed  error location: ±k for an error of ±2^(k-1), or 0.
REQ-016 The block SHALL have port out_status  out  2  00 no error, 01 corrected, 10 uncorrectable, 11 reserved.

Function
REQ-017 The block SHALL implement an FSM with states IDLE, SEARCH and DONE.
REQ-018 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-019 An accept SHALL occur on a rising edge with in_valid & in_ready, registering in_code and in_rem (accept edge = T).
REQ-020 On accept with in_rem == 0, the FSM SHALL go to DONE at T+1 with status 00, loc 0 and out_code = in_code.
REQ-021 On accept with in_rem ≥ A, the FSM SHALL go to DONE at T+1 with status 10, loc 0 and out_code = in_code.
REQ-022 Otherwise the FSM SHALL enter SEARCH with k=1, pos=1 and neg=A-1.
REQ-023 Each SEARCH cycle SHALL compare rem to pos and to neg, then update k=k+1, pos = (2·pos ≥ A) ? 2·pos−A : 2·pos, and neg = A−pos(new).
REQ-024 A match rem==pos at step k SHALL mean an error of +2^(k-1), giving out_code = code − 2^(k-1), loc = +k, status 01.
REQ-025 A match rem==neg at step k SHALL mean an error of −2^(k-1), giving out_code = code + 2^(k-1), loc = −k, status 01.
REQ-026 For a match at step k, DONE SHALL be entered at T+k+1, and the search SHALL stop at the first match.
REQ-027 If no match occurs by k == NPOS, the FSM SHALL enter DONE at T+NPOS+1 with status 10, loc 0 and out_code = code.
REQ-028 A correction that would underflow below 0 or overflow past 2^CW−1 SHALL give status 10, loc 0 and out_code = code unmodified.
REQ-029 DONE SHALL hold all outputs stable until out_ready is 1; on that edge the FSM SHALL return to IDLE, with no same-cycle re-accept.
REQ-030 in_code and in_rem SHALL be ignored outside IDLE.
REQ-031 pos and neg SHALL always lie in [1, A−1], and arithmetic SHALL use RW+1 bits for 2·pos.
REQ-032 An A parameter that is even or less than 3 SHALL cause an elaboration-time error.

Reset
REQ-033 When rst_n=0 at a rising edge, the block SHALL set state=IDLE, out_valid=0, out_code=0, out_loc=0, out_status=00, k=0, pos=0 and neg=0.
REQ-034 After that reset edge, in_ready SHALL be 1.
REQ-035 A reset asserted in SEARCH or DONE SHALL abort the operation, with no result emitted afterwards.
REQ-036 Reset SHALL take priority over any handshake on the same edge.

Structure
REQ-037 Package an_code_pkg SHALL hold the status enum (ST_NOERR, ST_CORR, ST_UNCORR) and the default A, RW and CW constants.
REQ-038 Sub-module an_mod_double (parameters A, RW) SHALL implement the combinational pos → 2·pos mod A step.
REQ-039 The FSM, counters and correction adder SHALL live in an_sec_search.

Verification (defaults A=6311, CW=33, NPOS=33)
REQ-040 Stimulus in_rem=0, in_code=1234 SHALL produce out_valid at T+1, status 00, loc 0 and code 1234.
REQ-041 Stimulus in_rem=1, in_code=100 SHALL produce DONE at T+2, loc +1, code 99, status 01; in_rem=1881, in_code=10000 SHALL produce loc +14, code 1808 at T+15.
REQ-042 Stimulus in_rem=4430, in_code=5 SHALL produce loc −14 and code 8197.
REQ-043 Stimulus in_rem=4499, in_code=5 SHALL produce loc −32 and code 0x0_8000_0005 at T+33.
REQ-044 Stimulus in_rem=3 SHALL produce status 10 at T+34, and in_rem=7000 SHALL produce status 10 at T+1.
REQ-045 Holding out_ready=0 for 5 cycles in DONE SHALL keep all outputs stable and in_ready=0.
REQ-046 rst_n=0 at step k=10 SHALL produce out_valid=0 and in_ready=1 on the next cycle.

Source files
------------

// File: rtl/an_code_pkg.sv
// Shared definitions for the AN-code single-error-correction search.
// Holds the default code parameters, the result status encoding and the
// search FSM state encoding.
package an_code_pkg;

  localparam int unsigned DefaultA  = 6311;
  localparam int unsigned DefaultRw = 13;
  localparam int unsigned DefaultCw = 33;

  // Result status reported alongside the corrected codeword (2'b11 reserved).
  typedef enum logic [1:0] {
    ST_NOERR  = 2'b00,
    ST_CORR   = 2'b01,
    ST_UNCORR = 2'b10
  } an_status_e;

  typedef enum logic [1:0] {
    StIdle,
    StSearch,
    StDone
  } an_state_e;

endpackage

// File: rtl/an_mod_double.sv
// Combinational modular doubling step: dbl_o = (2 * pos_i) mod A.
// pos_i must lie in [0, A-1]; the doubled value is formed in RW+1 bits so a
// single conditional subtraction of A is enough to reduce it.
// Ports:
//   pos_i  current residue 2^(k-1) mod A
//   dbl_o  next residue 2^k mod A
module an_mod_double
  import an_code_pkg::*;
#(
  parameter int unsigned A  = DefaultA,
  parameter int unsigned RW = DefaultRw
) (
  input  logic [RW-1:0] pos_i,
  output logic [RW-1:0] dbl_o
);

  localparam logic [RW:0] AExt = (RW+1)'(A);

  logic [RW:0] two;
  logic [RW:0] red;

  always_comb begin
    two   = {pos_i, 1'b0};
    red   = two - AExt;
    dbl_o = (two >= AExt) ? red[RW-1:0] : two[RW-1:0];
  end

endmodule

// File: rtl/an_sec_search.sv
// AN-code single-error correction by sequential search.
// Given a codeword and its residue mod A, walks k = 1..NPOS comparing the
// residue against +2^(k-1) mod A and -2^(k-1) mod A; the first hit names the
// erroneous bit and sign, and the codeword is corrected by the opposite value.
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   in_valid/in_ready            request handshake (ready only when idle)
//   in_code, in_rem              received codeword and its residue mod A
//   out_valid/out_ready          result handshake (valid only in done)
//   out_code, out_loc, out_status corrected word, signed location, status
module an_sec_search
  import an_code_pkg::*;
#(
  parameter int unsigned A    = DefaultA,
  parameter int unsigned RW   = DefaultRw,
  parameter int unsigned CW   = DefaultCw,
  parameter int unsigned NPOS = 33,
  parameter int unsigned LW   = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CW-1:0]        in_code,
  input  logic [RW-1:0]        in_rem,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        out_code,
  output logic signed [LW-1:0] out_loc,
  output logic [1:0]           out_status
);

  if ((A % 2 == 0) || (A < 3)) begin : g_bad_a
    $error("an_sec_search: parameter A must be odd and at least 3");
  end

  localparam logic [RW:0]   AExt  = (RW+1)'(A);
  localparam logic [RW-1:0] AM1   = RW'(A - 1);
  localparam logic [LW-1:0] KOne  = LW'(1);
  localparam logic [LW-1:0] KLast = LW'(NPOS);

  an_state_e         state_q, state_d;
  logic [CW-1:0]     code_q, code_d;
  logic [RW-1:0]     rem_q, rem_d;
  logic [LW-1:0]     k_q, k_d;
  logic [RW-1:0]     pos_q, pos_d;
  logic [RW-1:0]     neg_q, neg_d;
  logic [CW-1:0]     out_code_q, out_code_d;
  logic [LW-1:0]     out_loc_q, out_loc_d;
  an_status_e        out_status_q, out_status_d;

  logic [RW-1:0]     pos_dbl;
  logic [RW:0]       neg_next;
  logic [CW:0]       bit_val;
  logic [CW:0]       code_sub;
  logic [CW:0]       code_add;

  an_mod_double #(
    .A  (A),
    .RW (RW)
  ) u_mod_double (
    .pos_i (pos_q),
    .dbl_o (pos_dbl)
  );

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    rem_d        = rem_q;
    k_d          = k_q;
    pos_d        = pos_q;
    neg_d        = neg_q;
    out_code_d   = out_code_q;
    out_loc_d    = out_loc_q;
    out_status_d = out_status_q;

    neg_next = AExt - {1'b0, pos_dbl};
    // Candidate error magnitude 2^(k-1); the extra top bit catches wrap.
    bit_val  = {{CW{1'b0}}, 1'b1} << (k_q - KOne);
    code_sub = {1'b0, code_q} - bit_val;
    code_add = {1'b0, code_q} + bit_val;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          code_d = in_code;
          rem_d  = in_rem;
          if (in_rem == '0) begin
            state_d      = StDone;
            out_code_d   = in_code;
            out_loc_d    = '0;
            out_status_d = ST_NOERR;
          end else if ({1'b0, in_rem} >= AExt) begin
            // Residue out of range cannot come from a single-bit error.
            state_d      = StDone;
            out_code_d   = in_code;
            out_loc_d    = '0;
            out_status_d = ST_UNCORR;
          end else begin
            state_d = StSearch;
            k_d     = KOne;
            pos_d   = RW'(1);
            neg_d   = AM1;
          end
        end
      end

      StSearch: begin
        if (rem_q == pos_q) begin
          // Error of +2^(k-1): subtract it back out.
          state_d = StDone;
          if (code_sub[CW]) begin
            out_code_d   = code_q;
            out_loc_d    = '0;
            out_status_d = ST_UNCORR;
          end else begin
            out_code_d   = code_sub[CW-1:0];
            out_loc_d    = k_q;
            out_status_d = ST_CORR;
          end
        end else if (rem_q == neg_q) begin
          // Error of -2^(k-1): add it back in.
          state_d = StDone;
          if (code_add[CW]) begin
            out_code_d   = code_q;
            out_loc_d    = '0;
            out_status_d = ST_UNCORR;
          end else begin
            out_code_d   = code_add[CW-1:0];
            out_loc_d    = -k_q;
            out_status_d = ST_CORR;
          end
        end else if (k_q == KLast) begin
          state_d      = StDone;
          out_code_d   = code_q;
          out_loc_d    = '0;
          out_status_d = ST_UNCORR;
        end else begin
          k_d   = k_q + KOne;
          pos_d = pos_dbl;
          neg_d = neg_next[RW-1:0];
        end
      end

      StDone: begin
        if (out_ready) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      code_q       <= '0;
      rem_q        <= '0;
      k_q          <= '0;
      pos_q        <= '0;
      neg_q        <= '0;
      out_code_q   <= '0;
      out_loc_q    <= '0;
      out_status_q <= ST_NOERR;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      rem_q        <= rem_d;
      k_q          <= k_d;
      pos_q        <= pos_d;
      neg_q        <= neg_d;
      out_code_q   <= out_code_d;
      out_loc_q    <= out_loc_d;
      out_status_q <= out_status_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign out_code   = out_code_q;
  assign out_loc    = $signed(out_loc_q);
  assign out_status = out_status_q;

endmodule

// File: tb/tb_an_sec_search.sv
module tb_an_sec_search;

  localparam int CW = 33;
  localparam int RW = 13;
  localparam int LW = 7;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [CW-1:0]        in_code;
  logic [RW-1:0]        in_rem;
  logic                 out_valid;
  logic                 out_ready;
  logic [CW-1:0]        out_code;
  logic signed [LW-1:0] out_loc;
  logic [1:0]           out_status;

  int total = 0;
  int bad   = 0;

  an_sec_search dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .in_rem     (in_rem),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_code   (out_code),
    .out_loc    (out_loc),
    .out_status (out_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, measure edges from accept to out_valid, check result,
  // then release it and confirm the block is idle again.
  task automatic run_req(input string tag, input logic [CW-1:0] code, input logic [RW-1:0] rem,
                         input int exp_lat, input logic [1:0] exp_st,
                         input logic signed [LW-1:0] exp_loc, input logic [CW-1:0] exp_code);
    int lat;
    in_code  = code;
    in_rem   = rem;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_code  = '1;
    in_rem   = '1;
    lat = 1;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    chk({tag, " valid"}, 64'(out_valid), 64'd1);
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " status"}, 64'(out_status), 64'(exp_st));
    chk({tag, " loc"}, 64'(unsigned'(out_loc)), 64'(unsigned'(exp_loc)));
    chk({tag, " code"}, 64'(out_code), 64'(exp_code));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, " back idle"}, 64'({in_ready, out_valid}), 64'b10);
  endtask

  initial begin
    logic [CW-1:0]        hold_code;
    logic signed [LW-1:0] hold_loc;
    logic [1:0]           hold_st;
    int                   seen;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_code   = '0;
    in_rem    = '0;
    step();
    step();
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out_code", 64'(out_code), 64'd0);
    chk("rst out_loc", 64'(unsigned'(out_loc)), 64'd0);
    chk("rst out_status", 64'(out_status), 64'd0);
    rst_n = 1'b1;
    step();

    run_req("noerr",   33'd1234,  13'd0,    1,  2'b00, 7'sd0,   33'd1234);
    run_req("plus1",   33'd100,   13'd1,    2,  2'b01, 7'sd1,   33'd99);
    run_req("plus14",  33'd10000, 13'd1881, 15, 2'b01, 7'sd14,  33'd1808);
    run_req("minus14", 33'd5,     13'd4430, 15, 2'b01, -7'sd14, 33'd8197);
    run_req("minus32", 33'd5,     13'd4499, 33, 2'b01, -7'sd32, 33'h0_8000_0005);
    run_req("nomatch", 33'd77,    13'd3,    34, 2'b10, 7'sd0,   33'd77);
    run_req("remhigh", 33'd42,    13'd7000, 1,  2'b10, 7'sd0,   33'd42);
    // +2^13 error on a word smaller than 2^13 would underflow.
    run_req("under",   33'd5,     13'd1881, 15, 2'b10, 7'sd0,   33'd5);
    // -2^13 error on an all-ones word would overflow.
    run_req("over",    33'h1_FFFF_FFFF, 13'd4430, 15, 2'b10, 7'sd0, 33'h1_FFFF_FFFF);

    // Output hold while downstream stalls; new requests are ignored.
    in_code  = 33'd100;
    in_rem   = 13'd1;
    in_valid = 1'b1;
    step();
    in_code = 33'd555;
    in_rem  = 13'd0;
    step();
    chk("hold reach done", 64'(out_valid), 64'd1);
    hold_code = 33'd99;
    hold_loc  = 7'sd1;
    hold_st   = 2'b01;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold valid", 64'({out_valid, in_ready}), 64'b10);
      chk("hold code", 64'(out_code), 64'(hold_code));
      chk("hold loc", 64'(unsigned'(out_loc)), 64'(unsigned'(hold_loc)));
      chk("hold status", 64'(out_status), 64'(hold_st));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("hold release", 64'({in_ready, out_valid}), 64'b10);

    // Reset in the middle of a search: no result must ever appear.
    in_code  = 33'd9;
    in_rem   = 13'd3;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort out_valid", 64'(out_valid), 64'd0);
    chk("abort in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) seen++;
    end
    chk("abort no result", 64'(seen), 64'd0);

    run_req("after rst", 33'd1000, 13'd2, 3, 2'b01, 7'sd2, 33'd998);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
